// File: rtl/pulse_sweep_ctrl_pkg.sv
// pulse_sweep_ctrl_pkg: sweep FSM states, timing constants and config sanitising
package pulse_sweep_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int DUTY_PIPE_LAT = 2;
  localparam int LOAD_CYCLES = 3;
  localparam int MIN_ADVANCE = 4;
  function automatic logic [63:0] sanitise_nonzero(input logic [63:0] v);
    return (v == 64'd0) ? 64'd1 : v;
  endfunction
endpackage

// File: rtl/pulse_sweep_ctrl_duty_calc.sv
// sweep_duty_calc: two-stage registered duty = clamp((div_in * frac) >> FRAC_W)
module sweep_duty_calc
  import pulse_sweep_ctrl_pkg::*;
#(
  parameter int DIV_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DIV_W-1:0] div_in,
  input  logic [FRAC_W-1:0] frac,
  output logic [DIV_W-1:0] duty,
  output logic             valid
);
  localparam int PW = DIV_W + FRAC_W;
  logic [DIV_W-1:0] q_s1, div_s1, duty_c;
  logic [DUTY_PIPE_LAT-1:0] vpipe;
  always_comb duty_c = (div_s1 <= DIV_W'(1)) ? DIV_W'(1) :
                       (q_s1 >= div_s1) ? div_s1 - DIV_W'(1) :
                       (q_s1 == '0) ? DIV_W'(1) : q_s1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1 <= '0;
      div_s1 <= DIV_W'(1);
      duty <= DIV_W'(1);
      vpipe <= '0;
    end else begin
      q_s1 <= DIV_W'((PW'(div_in) * PW'(frac)) >> FRAC_W);
      div_s1 <= div_in;
      duty <= duty_c;
      vpipe <= {vpipe[DUTY_PIPE_LAT-2:0], in_valid};
    end
  end
  assign valid = vpipe[DUTY_PIPE_LAT-1];
endmodule

// File: rtl/pulse_sweep_ctrl.sv
// pulse_sweep_ctrl: steps divider/duty start->stop on pulse-period boundaries with dwell
module pulse_sweep_ctrl
  import pulse_sweep_ctrl_pkg::*;
#(
  parameter int DIV_W = 32,
  parameter int FRAC_W = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic [DIV_W-1:0]   start_div,
  input  logic [DIV_W-1:0]   stop_div,
  input  logic [DIV_W-1:0]   step_div,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [FRAC_W-1:0]  duty_frac,
  input  logic               repeat_en,
  output logic [DIV_W-1:0]   divider,
  output logic [DIV_W-1:0]   duty,
  output logic               period_strobe,
  output logic [DWELL_W-1:0] step_idx,
  output logic               sweeping,
  output logic               done
);
  state_t state, state_nx;
  logic [DIV_W-1:0] sh_start, sh_stop, sh_step, start_s, stop_s;
  logic [DWELL_W-1:0] sh_dwell, dcnt;
  logic [FRAC_W-1:0] sh_frac;
  logic sh_rep, sh_up;
  logic [1:0] load_cnt;
  logic [DIV_W-1:0] pcnt, next_div, calc_in, calc_duty;
  logic [DIV_W:0] up_sum, dn_diff;
  logic [2:0] adv_cnt;
  logic calc_valid, at_stop, dwell_done, adv_ok, advance, take_arm;
  assign start_s = DIV_W'(sanitise_nonzero(64'(start_div)));
  assign stop_s = DIV_W'(sanitise_nonzero(64'(stop_div)));
  assign up_sum = {1'b0, divider} + {1'b0, sh_step};
  assign dn_diff = {1'b0, divider} - {1'b0, sh_step};
  assign next_div = sh_up ?
    ((up_sum[DIV_W] || up_sum[DIV_W-1:0] > sh_stop) ? sh_stop : up_sum[DIV_W-1:0]) :
    ((dn_diff[DIV_W] || dn_diff[DIV_W-1:0] < sh_stop) ? sh_stop : dn_diff[DIV_W-1:0]);
  assign at_stop = divider == sh_stop;
  assign calc_in = (state == RUN && !at_stop) ? next_div : sh_start;
  assign period_strobe = state == RUN && pcnt == divider - DIV_W'(1);
  assign dwell_done = dcnt >= sh_dwell - DWELL_W'(1);
  assign adv_ok = adv_cnt >= 3'(MIN_ADVANCE - 1);
  assign advance = period_strobe && dwell_done && adv_ok && calc_valid;
  assign take_arm = arm && (state == IDLE || state == DONE);
  assign sweeping = state == RUN;
  assign done = state == DONE;
  sweep_duty_calc #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_calc (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(state == LOAD || state == RUN),
    .div_in(calc_in),
    .frac(sh_frac),
    .duty(calc_duty),
    .valid(calc_valid)
  );
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (take_arm) state_nx = LOAD;
    else if (state == LOAD && load_cnt == 2'(LOAD_CYCLES - 1)) state_nx = RUN;
    else if (advance && at_stop && !sh_rep) state_nx = DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_start <= DIV_W'(1);
      sh_stop <= DIV_W'(1);
      sh_step <= DIV_W'(1);
      sh_dwell <= DWELL_W'(1);
      sh_frac <= '0;
      sh_rep <= 1'b0;
      sh_up <= 1'b1;
      load_cnt <= '0;
      pcnt <= '0;
      dcnt <= '0;
      adv_cnt <= '0;
      divider <= DIV_W'(1);
      duty <= DIV_W'(1);
      step_idx <= '0;
    end else begin
      if (!abort && take_arm) begin
        sh_start <= start_s;
        sh_stop <= stop_s;
        sh_step <= DIV_W'(sanitise_nonzero(64'(step_div)));
        sh_dwell <= DWELL_W'(sanitise_nonzero(64'(dwell)));
        sh_frac <= duty_frac;
        sh_rep <= repeat_en;
        sh_up <= stop_s >= start_s;
        load_cnt <= '0;
      end
      if (state == LOAD) load_cnt <= load_cnt + 2'd1;
      if (state == LOAD && state_nx == RUN) begin
        divider <= sh_start;
        duty <= calc_duty;
        step_idx <= '0;
        pcnt <= '0;
        dcnt <= '0;
        adv_cnt <= '0;
      end
      if (state == RUN && !abort) begin
        pcnt <= period_strobe ? '0 : pcnt + DIV_W'(1);
        adv_cnt <= adv_ok ? adv_cnt : adv_cnt + 3'd1;
        if (period_strobe) dcnt <= dwell_done ? dcnt : dcnt + DWELL_W'(1);
        if (advance) begin
          dcnt <= '0;
          adv_cnt <= '0;
          if (!at_stop || sh_rep) begin
            divider <= calc_in;
            duty <= calc_duty;
            step_idx <= at_stop ? '0 : step_idx + DWELL_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pulse_sweep_ctrl.sv
// tb_pulse_sweep_ctrl: directed scenarios for pulse_sweep_ctrl with hand-computed expectations
module tb_pulse_sweep_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, abort = 1'b0, repeat_en = 1'b0;
  logic [31:0] start_div = '0, stop_div = '0, step_div = '0, divider, duty;
  logic [15:0] dwell = '0, duty_frac = '0, step_idx;
  logic period_strobe, sweeping, done;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pulse_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .start_div(start_div), .stop_div(stop_div), .step_div(step_div),
    .dwell(dwell), .duty_frac(duty_frac), .repeat_en(repeat_en),
    .divider(divider), .duty(duty), .period_strobe(period_strobe),
    .step_idx(step_idx), .sweeping(sweeping), .done(done)
  );
  task automatic do_arm(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                        input logic [15:0] dw, input logic [15:0] fr, input logic rp);
    start_div = s; stop_div = p; step_div = st; dwell = dw; duty_frac = fr; repeat_en = rp; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    start_div = 32'd999; stop_div = 32'd3; step_div = 32'd50; dwell = 16'd7; duty_frac = 16'h1234; repeat_en = ~rp;
  endtask
  task automatic wait_run(output int lat);
    lat = 1;
    while (!sweeping && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic measure(output int len, output int nstb, output int first);
    logic [31:0] d0;
    d0 = divider; len = 0; nstb = 0; first = -1;
    while (divider == d0 && sweeping && len < 2000) begin
      if (period_strobe) begin
        if (first < 0) first = len;
        nstb++;
      end
      len++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (divider !== 32'd1 || duty !== 32'd1 || step_idx !== 16'd0 || period_strobe !== 1'b0 || sweeping !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset got div=%0d duty=%0d idx=%0d stb=%0b sw=%0b done=%0b want 1 1 0 0 0 0", divider, duty, step_idx, period_strobe, sweeping, done);
    end
  endtask
  task automatic test_up_sweep();
    int lat, len, nstb, first;
    int ed[3] = '{4, 7, 10};
    int eq[3] = '{2, 3, 5};
    do_arm(32'd4, 32'd10, 32'd3, 16'd2, 16'h8000, 1'b0);
    wait_run(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL up_load_latency got %0d want 4", lat); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (divider !== 32'(ed[i]) || duty !== 32'(eq[i]) || step_idx !== 16'(i)) begin
        errors++;
        $display("FAIL up_step%0d got div=%0d duty=%0d idx=%0d want div=%0d duty=%0d idx=%0d", i, divider, duty, step_idx, ed[i], eq[i], i);
      end
      measure(len, nstb, first);
      checks++;
      if (len != 2 * ed[i] || nstb != 2 || first != ed[i] - 1) begin
        errors++;
        $display("FAIL up_timing%0d got len=%0d strobes=%0d first=%0d want len=%0d strobes=2 first=%0d", i, len, nstb, first, 2 * ed[i], ed[i] - 1);
      end
    end
    checks++;
    if (done !== 1'b1 || sweeping !== 1'b0 || divider !== 32'd10 || duty !== 32'd5) begin
      errors++;
      $display("FAIL up_done got done=%0b sw=%0b div=%0d duty=%0d want 1 0 10 5", done, sweeping, divider, duty);
    end
  endtask
  task automatic test_down_sweep();
    int lat, len, nstb, first;
    int ed[4] = '{20, 14, 8, 5};
    int eq[4] = '{5, 3, 2, 1};
    do_arm(32'd20, 32'd5, 32'd6, 16'd1, 16'h4000, 1'b0);
    wait_run(lat);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (divider !== 32'(ed[i]) || duty !== 32'(eq[i]) || step_idx !== 16'(i)) begin
        errors++;
        $display("FAIL down_step%0d got div=%0d duty=%0d idx=%0d want div=%0d duty=%0d idx=%0d", i, divider, duty, step_idx, ed[i], eq[i], i);
      end
      measure(len, nstb, first);
      checks++;
      if (len != ed[i] || nstb != 1) begin
        errors++;
        $display("FAIL down_timing%0d got len=%0d strobes=%0d want len=%0d strobes=1", i, len, nstb, ed[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || divider !== 32'd5 || duty !== 32'd1) begin
      errors++;
      $display("FAIL down_done got done=%0b div=%0d duty=%0d want 1 5 1", done, divider, duty);
    end
  endtask
  task automatic test_repeat();
    int lat, len, nstb, first;
    int ed[3] = '{4, 7, 10};
    do_arm(32'd4, 32'd10, 32'd3, 16'd2, 16'h8000, 1'b1);
    wait_run(lat);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (divider !== 32'(ed[i]) || step_idx !== 16'(i) || done !== 1'b0) begin
        errors++;
        $display("FAIL rep_step%0d got div=%0d idx=%0d done=%0b want div=%0d idx=%0d done=0", i, divider, step_idx, done, ed[i], i);
      end
      measure(len, nstb, first);
    end
    checks++;
    if (divider !== 32'd4 || duty !== 32'd2 || step_idx !== 16'd0 || done !== 1'b0 || sweeping !== 1'b1 || len != 20) begin
      errors++;
      $display("FAIL rep_wrap got div=%0d duty=%0d idx=%0d done=%0b sw=%0b len=%0d want 4 2 0 0 1 20", divider, duty, step_idx, done, sweeping, len);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (sweeping !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rep_abort got sw=%0b done=%0b want 0 0", sweeping, done);
    end
  endtask
  task automatic test_degenerate();
    int lat, len, nstb, first;
    do_arm(32'd0, 32'd1, 32'd0, 16'd0, 16'hFFFF, 1'b0);
    wait_run(lat);
    checks++;
    if (lat != 4 || divider !== 32'd1 || duty !== 32'd1 || step_idx !== 16'd0) begin
      errors++;
      $display("FAIL degen_start got lat=%0d div=%0d duty=%0d idx=%0d want 4 1 1 0", lat, divider, duty, step_idx);
    end
    measure(len, nstb, first);
    checks++;
    if (len != 4 || nstb != 4 || first != 0) begin
      errors++;
      $display("FAIL degen_min_advance got len=%0d strobes=%0d first=%0d want 4 4 0", len, nstb, first);
    end
    checks++;
    if (done !== 1'b1 || divider !== 32'd1 || duty !== 32'd1) begin
      errors++;
      $display("FAIL degen_done got done=%0b div=%0d duty=%0d want 1 1 1", done, divider, duty);
    end
  endtask
  task automatic test_abort();
    int lat, len, nstb, first;
    do_arm(32'd4, 32'd10, 32'd3, 16'd2, 16'h8000, 1'b0);
    wait_run(lat);
    measure(len, nstb, first);
    repeat (3) @(negedge clk);
    checks++;
    if (divider !== 32'd7 || sweeping !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got div=%0d sw=%0b want 7 1", divider, sweeping);
    end
    abort = 1'b1; arm = 1'b1;
    @(negedge clk);
    abort = 1'b0; arm = 1'b0;
    checks++;
    if (sweeping !== 1'b0 || done !== 1'b0 || divider !== 32'd7 || duty !== 32'd3) begin
      errors++;
      $display("FAIL abort_hold got sw=%0b done=%0b div=%0d duty=%0d want 0 0 7 3", sweeping, done, divider, duty);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (sweeping !== 1'b0 || divider !== 32'd7 || step_idx !== 16'd1) begin
      errors++;
      $display("FAIL abort_arm_ignored got sw=%0b div=%0d idx=%0d want 0 7 1", sweeping, divider, step_idx);
    end
  endtask
  task automatic test_async_reset();
    int lat, len, nstb, first;
    do_arm(32'd20, 32'd5, 32'd6, 16'd1, 16'h4000, 1'b0);
    wait_run(lat);
    measure(len, nstb, first);
    @(negedge clk);
    checks++;
    if (divider !== 32'd14 || step_idx !== 16'd1) begin
      errors++;
      $display("FAIL areset_pre got div=%0d idx=%0d want 14 1", divider, step_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (divider !== 32'd1 || duty !== 32'd1 || step_idx !== 16'd0 || sweeping !== 1'b0 || done !== 1'b0 || period_strobe !== 1'b0) begin
      errors++;
      $display("FAIL areset got div=%0d duty=%0d idx=%0d sw=%0b done=%0b stb=%0b want 1 1 0 0 0 0", divider, duty, step_idx, sweeping, done, period_strobe);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_repeat();
    test_degenerate();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
